// File: rtl/dog_motion_pkg.sv
// Shared encodings and screen geometry for the dog sprite motion controller.
package dog_motion_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        JUMP = 2'd2
    } state_t;

    localparam logic [2:0] ACTION_SIT  = 3'd7;
    localparam logic [2:0] ACTION_JUMP = 3'd6;
    localparam int         RUN_FRAMES  = 6;

    localparam int SCREEN_W = 640;
    localparam int SPRITE_W = 64;

endpackage

// File: rtl/frame_tick_gen.sv
// Pixel-clock frame counter; frame_tick is high in the cycle the counter sits at FRAME_CYCLES-1.
module frame_tick_gen #(
    parameter int FRAME_CYCLES = 420000
) (
    input  logic pixel_clk,
    input  logic reset,
    output logic frame_tick
);

    localparam int CNT_W = $clog2(FRAME_CYCLES);

    logic [CNT_W-1:0] cnt;

    // frame_tick is registered one count early so it lines up with cnt == FRAME_CYCLES-1
    always_ff @(posedge pixel_clk) begin
        if (!reset) begin
            cnt        <= '0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= (cnt == CNT_W'(FRAME_CYCLES - 1)) ? '0 : cnt + 1'b1;
            frame_tick <= (cnt == CNT_W'(FRAME_CYCLES - 2));
        end
    end

endmodule

// File: rtl/dog_motion_ctrl.sv
// Frame-rate sit/run/jump sequencer for the dog sprite layer.
// Optional DOG_BOUNCE_EN: dog bounces between screen edges instead of wrapping x to 0.
//
// state | meaning
// IDLE  | sitting, x/y held, ActionSel = 7
// RUN   | run cycle sprites 0-5, x advances every frame
// JUMP  | airborne under gravity, ActionSel = 6, x keeps advancing
module dog_motion_ctrl
    import dog_motion_pkg::*;
#(
    parameter int FRAME_CYCLES    = 420000,
    parameter int FRAMES_PER_STEP = 4,
    parameter int STEP_X          = 4,
    parameter int X_MAX           = SCREEN_W - SPRITE_W,
    parameter int GROUND_Y        = 300,
    parameter int JUMP_V0         = 12,
    parameter int GRAVITY         = 1
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic       run,
    input  logic       jump,
    output logic       frame_tick,
    output logic [2:0] ActionSel,
    output logic [9:0] DogPos_x,
    output logic [8:0] DogPos_y
);

    localparam int STEP_W = $clog2(FRAMES_PER_STEP + 1);

    state_t              state;
    logic [STEP_W-1:0]   step_cnt;
    logic signed [5:0]   vel;
    logic                pending;

    logic                jump_req;
    logic                x_moves;
    logic [10:0]         x_sum;
    logic [9:0]          x_adv;
    logic signed [5:0]   vel_next;
    logic signed [10:0]  y_next;
    logic                landing;

    frame_tick_gen #(.FRAME_CYCLES(FRAME_CYCLES)) u_frame_tick_gen (
        .pixel_clk  (pixel_clk),
        .reset      (reset),
        .frame_tick (frame_tick)
    );

    assign jump_req = pending | jump;
    assign x_moves  = frame_tick && (((state == RUN) && (jump_req || run)) || (state == JUMP));
    assign x_sum    = {1'b0, DogPos_x} + 11'(STEP_X);
    assign vel_next = vel - $signed(6'(GRAVITY));
    assign y_next   = $signed({2'b00, DogPos_y}) - $signed({{5{vel_next[5]}}, vel_next});
    assign landing  = (y_next >= $signed(11'(GROUND_Y)));

`ifdef DOG_BOUNCE_EN
    logic dir_left;
    logic dir_flip;

    always_comb begin
        x_adv    = x_sum[9:0];
        dir_flip = 1'b0;
        if (dir_left) begin
            if (DogPos_x < 10'(STEP_X)) begin
                x_adv    = '0;
                dir_flip = 1'b1;
            end else begin
                x_adv = DogPos_x - 10'(STEP_X);
            end
        end else if (x_sum > 11'(X_MAX)) begin
            x_adv    = 10'(X_MAX);
            dir_flip = 1'b1;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!reset) begin
            dir_left <= 1'b0;
        end else if (x_moves && dir_flip) begin
            dir_left <= ~dir_left;
        end
    end
`else
    assign x_adv = (x_sum > 11'(X_MAX)) ? '0 : x_sum[9:0];
`endif

    always_ff @(posedge pixel_clk) begin
        if (!reset) begin
            state     <= IDLE;
            ActionSel <= ACTION_SIT;
            DogPos_x  <= '0;
            DogPos_y  <= 9'(GROUND_Y);
            step_cnt  <= '0;
            vel       <= '0;
            pending   <= 1'b0;
        end else if (frame_tick) begin
            pending <= 1'b0;
            if (x_moves) begin
                DogPos_x <= x_adv;
            end
            unique case (state)
                IDLE: begin
                    if (run) begin
                        state     <= RUN;
                        ActionSel <= 3'd0;
                        step_cnt  <= '0;
                    end
                end
                RUN: begin
                    if (jump_req) begin
                        state     <= JUMP;
                        ActionSel <= ACTION_JUMP;
                        vel       <= 6'(JUMP_V0);
                        DogPos_y  <= 9'(GROUND_Y - JUMP_V0);
                    end else if (!run) begin
                        state     <= IDLE;
                        ActionSel <= ACTION_SIT;
                    end else if (step_cnt == STEP_W'(FRAMES_PER_STEP - 1)) begin
                        step_cnt  <= '0;
                        ActionSel <= (ActionSel == 3'(RUN_FRAMES - 1)) ? 3'd0 : ActionSel + 3'd1;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                JUMP: begin
                    vel <= vel_next;
                    if (landing) begin
                        DogPos_y <= 9'(GROUND_Y);
                        if (run) begin
                            state     <= RUN;
                            ActionSel <= 3'd0;
                            step_cnt  <= '0;
                        end else begin
                            state     <= IDLE;
                            ActionSel <= ACTION_SIT;
                        end
                    end else begin
                        DogPos_y <= y_next[8:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end else begin
            // several pulses inside one frame collapse into a single request
            pending <= pending | jump;
        end
    end

endmodule

// File: tb/tb_dog_motion_ctrl.sv
// Randomized bench for dog_motion_ctrl against a frame-level behavioural model (FRAME_CYCLES=16).
module tb_dog_motion_ctrl;

    localparam int FC   = 16;
    localparam int FPS  = 4;
    localparam int SX   = 4;
    localparam int XM   = 576;
    localparam int GY   = 300;
    localparam int V0   = 12;
    localparam int GRAV = 1;

    localparam int M_SIT      = 0;
    localparam int M_RUNNING  = 1;
    localparam int M_AIRBORNE = 2;

    logic       pixel_clk = 1'b0;
    logic       reset     = 1'b0;
    logic       run       = 1'b0;
    logic       jump      = 1'b0;
    logic       frame_tick;
    logic [2:0] ActionSel;
    logic [9:0] DogPos_x;
    logic [8:0] DogPos_y;

    int n_checks = 0;
    int n_errors = 0;

    int m_phase;
    int m_mode;
    int m_x;
    int m_run_ticks;
    int m_jk;
    bit m_pending;
    bit m_dir_left;
    bit saw_x_max;

    dog_motion_ctrl #(.FRAME_CYCLES(FC)) dut (
        .pixel_clk  (pixel_clk),
        .reset      (reset),
        .run        (run),
        .jump       (jump),
        .frame_tick (frame_tick),
        .ActionSel  (ActionSel),
        .DogPos_x   (DogPos_x),
        .DogPos_y   (DogPos_y)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // height above ground after k frames of flight (k=1 is the take-off frame)
    function automatic int jump_h(input int k);
        return V0 * k - GRAV * k * (k - 1) / 2;
    endfunction

    function automatic int exp_act();
        if (m_mode == M_SIT)      return 7;
        if (m_mode == M_AIRBORNE) return 6;
        return (m_run_ticks / FPS) % 6;
    endfunction

    function automatic int exp_y();
        return (m_mode == M_AIRBORNE) ? GY - jump_h(m_jk) : GY;
    endfunction

    task automatic advance_x();
`ifdef DOG_BOUNCE_EN
        if (m_dir_left) begin
            if (m_x < SX) begin m_x = 0; m_dir_left = 1'b0; end
            else m_x = m_x - SX;
        end else if (m_x + SX > XM) begin
            m_x = XM; m_dir_left = 1'b1;
        end else begin
            m_x = m_x + SX;
        end
`else
        m_x = (m_x + SX > XM) ? 0 : m_x + SX;
`endif
    endtask

    task automatic model_edge(input logic r_n, input logic rn, input logic jp);
        bit pend;
        if (!r_n) begin
            m_phase = 0; m_mode = M_SIT; m_x = 0; m_run_ticks = 0;
            m_jk = 0; m_pending = 1'b0; m_dir_left = 1'b0;
            return;
        end
        if (m_phase == FC - 1) begin
            pend = m_pending || jp;
            m_pending = 1'b0;
            case (m_mode)
                M_SIT: if (rn) begin m_mode = M_RUNNING; m_run_ticks = 0; end
                M_RUNNING: begin
                    if (pend) begin
                        m_mode = M_AIRBORNE; m_jk = 1; advance_x();
                    end else if (rn) begin
                        advance_x(); m_run_ticks++;
                    end else begin
                        m_mode = M_SIT;
                    end
                end
                default: begin
                    advance_x();
                    m_jk++;
                    if (jump_h(m_jk) <= 0) begin
                        m_mode = rn ? M_RUNNING : M_SIT;
                        m_run_ticks = 0;
                    end
                end
            endcase
        end else begin
            m_pending = m_pending || jp;
        end
        m_phase = (m_phase + 1) % FC;
    endtask

    task automatic step();
        @(posedge pixel_clk);
        model_edge(reset, run, jump);
        @(negedge pixel_clk);
        jump = 1'b0;
        check_val("frame_tick", int'(frame_tick), (m_phase == FC - 1) ? 1 : 0);
        check_val("ActionSel", int'(ActionSel), exp_act());
        check_val("DogPos_x", int'(DogPos_x), m_x);
        check_val("DogPos_y", int'(DogPos_y), exp_y());
        if (DogPos_x == 10'd576) saw_x_max = 1'b1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit found;
        saw_x_max = 1'b0;

        // reset held, then idle frames with run low
        reset = 1'b0; run = 1'b0;
        steps(3);
        reset = 1'b1;
        steps(5 * FC);

        // run long enough to cover sprite cycling and an x wrap
        run = 1'b1;
        steps(155 * FC);
        check_val("x_reached_max", int'(saw_x_max), 1);

        // jump from RUN with pulse at a random mid-frame cycle
        steps($urandom_range(1, 12));
        jump = 1'b1;
        steps(30 * FC);

        // jump then drop run mid-flight; then a jump pulse in IDLE
        jump = 1'b1;
        steps(5 * FC);
        run = 1'b0;
        steps(30 * FC);
        steps($urandom_range(1, 12));
        jump = 1'b1;
        steps(3 * FC);

        // reset mid-jump once y reaches 250
        run = 1'b1;
        steps(2 * FC);
        jump = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 * FC && !found; i++) begin
            step();
            if (exp_y() == 250) found = 1'b1;
        end
        check_val("wait_y250", int'(found), 1);
        steps($urandom_range(1, 10));
        reset = 1'b0;
        steps(1);
        reset = 1'b1;
        steps(3 * FC);

        // randomized mix of run level, jump pulses and rare resets
        for (int i = 0; i < 400 * FC; i++) begin
            if ($urandom_range(0, 99) == 0) run = ~run;
            jump  = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 1999) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
